// File: rtl/sm_fetch_unit_if.sv
// Instruction-memory request bus between the prefetch unit and memory.
// The fetch unit holds memReq/memAddr stable until it sees memAck.
interface sm_fetch_unit_if;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRData;

    modport master(
        output memReq,
        output memAddr,
        input  memAck,
        input  memRData
    );

    modport slave(
        input  memReq,
        input  memAddr,
        output memAck,
        output memRData
    );
endinterface

// File: rtl/sm_fetch_unit.sv
// Sequential instruction prefetcher with a DEPTH-entry {addr,data} queue.
// Flushes and refetches when the CPU PC leaves the predicted stream.
module sm_fetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     imAddr,
    input  logic            imAdvance,
    output logic [31:0]     imData,
    output logic            imValid,
    sm_fetch_unit_if.master mem
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptrT;
    typedef logic [PW:0]   cntT;

    logic [31:0] addrQ [DEPTH];
    logic [31:0] dataQ [DEPTH];
    ptrT         head;
    ptrT         tail;
    cntT         count;
    logic [31:0] fetchAddr;
    logic        discard;
    logic        reqR;
    logic [31:0] addrR;

    logic        notEmpty;
    logic        memDone;
    logic        pop;
    logic        push;
    logic        redirect;
    logic        issue;
    logic [31:0] expAddr;

    assign mem.memReq  = reqR;
    assign mem.memAddr = addrR;

    assign notEmpty = count != '0;
    assign imValid  = notEmpty && (addrQ[head] == imAddr);
    assign imData   = imValid ? dataQ[head] : '0;
    assign memDone  = reqR && mem.memAck;
    assign pop      = imAdvance && imValid;

    // Address the CPU is predicted to ask for next
    always_comb begin
        expAddr = fetchAddr;
        if (notEmpty) begin
            expAddr = addrQ[head];
        end else if (reqR && !discard) begin
            expAddr = addrR;
        end
    end

    assign redirect = !imValid && (expAddr != imAddr);
    assign push     = memDone && !discard && !redirect;
    assign issue    = !reqR && !redirect &&
                      ((count + cntT'(reqR)) < cntT'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            addrQ[tail] <= addrR;
            dataQ[tail] <= mem.memRData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            count <= count + cntT'(push) - cntT'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqR      <= 1'b0;
            addrR     <= '0;
            fetchAddr <= RESET_ADDR;
            discard   <= 1'b0;
        end else begin
            unique case (1'b1)
                issue: begin
                    reqR  <= 1'b1;
                    addrR <= fetchAddr;
                end
                memDone: reqR <= 1'b0;
                default: ;
            endcase
            if (redirect) begin
                fetchAddr <= imAddr;
            end else if (issue) begin
                fetchAddr <= fetchAddr + 32'd1;
            end
            // A redirect cannot cancel the bus cycle, so its reply is dropped
            if (memDone) begin
                discard <= 1'b0;
            end else if (redirect && reqR) begin
                discard <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sm_fetch_unit.sv
// Bench for sm_fetch_unit: directed scenarios plus a randomized CPU trace
// checked through a scoreboard against a memory returning addr+100.
module tb_sm_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imAddr;
    logic        imAdvance;
    logic [31:0] imData;
    logic        imValid;

    sm_fetch_unit_if mem();

    sm_fetch_unit #(
        .DEPTH(DEPTH),
        .RESET_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imAddr(imAddr),
        .imAdvance(imAdvance),
        .imData(imData),
        .imValid(imValid),
        .mem(mem)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory: latency fixedLat cycles (or random 0..3 when negative)
    int fixedLat = 0;
    int curLat = 0;
    int waitCnt = 0;

    function automatic int newLat();
        return (fixedLat < 0) ? int'($urandom_range(0, 3)) : fixedLat;
    endfunction

    initial begin
        mem.memAck = 1'b0;
        mem.memRData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem.memReq && waitCnt >= curLat) begin
                mem.memAck = 1'b1;
                mem.memRData = mem.memAddr + 32'd100;
                waitCnt = 0;
                curLat = newLat();
            end else if (mem.memReq) begin
                mem.memAck = 1'b0;
                mem.memRData = $urandom;
                waitCnt++;
            end else begin
                mem.memAck = 1'b0;
                mem.memRData = $urandom;
                waitCnt = 0;
                curLat = newLat();
            end
        end
    end

    // Bus protocol monitor and log of completed requests
    logic [31:0] ackLog[$];
    initial begin
        bit pReq;
        bit pAck;
        logic [31:0] pAddr;
        pReq = 0;
        pAck = 0;
        pAddr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pReq = 0;
                pAck = 0;
            end else begin
                if (pAck) begin
                    chk("req_gap", mem.memReq, 0);
                end else if (pReq) begin
                    chk("req_hold", mem.memReq, 1);
                    chk("addr_hold", mem.memAddr, pAddr);
                end
                if (mem.memReq && mem.memAck) ackLog.push_back(mem.memAddr);
                pReq = mem.memReq;
                pAck = mem.memReq && mem.memAck;
                pAddr = mem.memAddr;
            end
        end
    end

    // Randomized CPU: follows its own PC trace, branching at random
    bit randMode = 0;
    logic [31:0] pc;
    expT expQ[$];
    int consumed = 0;

    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = randMode && imValid && imAdvance;
            @(posedge clk);
            #1;
            if (randMode) begin
                if (fire) begin
                    if ($urandom_range(0, 5) == 0) begin
                        if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFD;
                        else pc = 32'($urandom_range(0, 500));
                    end else begin
                        pc = pc + 32'd1;
                    end
                    expQ.push_back('{addr: pc, data: pc + 32'd100});
                end
                imAddr = pc;
                imAdvance = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (randMode && rst_n && imValid) begin
                chk("sb_nonempty", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    chk("sb_data", imData, expQ[0].data);
                    if (imAdvance) begin
                        void'(expQ.pop_front());
                        consumed++;
                    end
                end
            end
        end
    end

    task automatic doReset(input logic [31:0] a, input logic adv);
        rst_n = 1'b0;
        imAddr = a;
        imAdvance = adv;
        repeat (2) @(posedge clk);
        ackLog.delete();
        expQ.delete();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic consumeSeq(input int n, input logic [31:0] first,
                              input string nm);
        int got;
        int guard;
        got = 0;
        guard = 0;
        while (got < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (imValid) begin
                chk(nm, imData, first + 32'(got) + 32'd100);
                if (imAdvance) begin
                    got++;
                    @(posedge clk);
                    #1;
                    imAddr = imAddr + 32'd1;
                end
            end
        end
        chk({nm, "_count"}, got, n);
    endtask

    task automatic waitValid(input string nm, input logic [31:0] expData);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!imValid && g < 50);
        chk({nm, "_seen"}, imValid, 1);
        chk({nm, "_data"}, imData, expData);
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        imAddr = '0;
        imAdvance = 1'b0;

        @(negedge clk);
        chk("rst_memReq", mem.memReq, 0);
        chk("rst_memAddr", mem.memAddr, 0);
        chk("rst_imValid", imValid, 0);
        chk("rst_imData", imData, 0);

        // Cold start
        fixedLat = 0;
        doReset(32'd0, 1'b1);
        @(negedge clk);
        chk("cs_c0_req", mem.memReq, 0);
        @(negedge clk);
        chk("cs_c1_req", mem.memReq, 1);
        chk("cs_c1_addr", mem.memAddr, 0);
        @(negedge clk);
        chk("cs_c2_valid", imValid, 1);
        chk("cs_c2_data", imData, 100);
        @(posedge clk);
        #1;
        imAddr = 32'd1;
        consumeSeq(10, 32'd1, "cs_seq");

        // Fill to full, then free one slot
        doReset(32'd0, 1'b0);
        repeat (20) @(negedge clk);
        chk("fill_reqs", ackLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ackLog.size()) chk("fill_addr", ackLog[i], i);
        end
        chk("fill_idle", mem.memReq, 0);
        chk("fill_head", imData, 100);
        @(posedge clk);
        #1;
        imAdvance = 1'b1;
        @(posedge clk);
        #1;
        imAdvance = 1'b0;
        imAddr = 32'd1;
        repeat (20) @(negedge clk);
        chk("pop_reqs", ackLog.size(), 5);
        if (ackLog.size() > 4) chk("pop_addr", ackLog[4], 4);
        chk("pop_idle", mem.memReq, 0);
        chk("pop_head", imData, 101);

        // Redirect with a populated queue
        ackLog.delete();
        @(posedge clk);
        #1;
        imAddr = 32'd20;
        waitValid("rdq", 32'd120);
        chk("rdq_first_req", (ackLog.size() > 0) ? ackLog[0] : 32'hX, 20);

        // Redirect while a slow request is outstanding
        fixedLat = 3;
        doReset(32'd5, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!mem.memReq && g < 10);
        chk("rdo_req", mem.memReq, 1);
        @(posedge clk);
        #1;
        imAddr = 32'd40;
        fixedLat = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rdo_hold_req", mem.memReq, 1);
            chk("rdo_hold_addr", mem.memAddr, 5);
        end
        waitValid("rdo", 32'd140);
        chk("rdo_nreq", ackLog.size() >= 2, 1);
        if (ackLog.size() >= 2) begin
            chk("rdo_old", ackLog[0], 5);
            chk("rdo_new", ackLog[1], 40);
        end

        // Concurrent push and pop across pointer wrap
        fixedLat = 0;
        doReset(32'd0, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (ackLog.size() < 2 && g < 20);
        @(posedge clk);
        #1;
        imAdvance = 1'b1;
        consumeSeq(14, 32'd0, "pp_seq");

        // Asynchronous reset while a request is on the bus
        doReset(32'd0, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while (!(mem.memReq && mem.memAddr == 32'd3) && g < 30);
        chk("ar_pre_valid", imValid, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_memReq", mem.memReq, 0);
        chk("ar_memAddr", mem.memAddr, 0);
        chk("ar_imValid", imValid, 0);
        chk("ar_imData", imData, 0);
        doReset(32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("ar_restart_req", mem.memReq, 1);
        chk("ar_restart_addr", mem.memAddr, 0);

        // Randomized trace with random memory latency
        fixedLat = -1;
        doReset(32'd0, 1'b1);
        pc = 32'd0;
        consumed = 0;
        expQ.push_back('{addr: 32'd0, data: 32'd100});
        randMode = 1;
        for (int c = 0; c < 20000 && consumed < 400; c++) @(posedge clk);
        randMode = 0;
        chk("sb_progress", consumed >= 400, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
